// File: rtl/aes_pkg.sv
// Purpose: shared AES types, constants and byte/word helpers for the cipher datapath.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  // Rounds for AES-128; the key schedule emits AES_NR+1 round keys.
  localparam int AES_NR  = 10;
  localparam int ROUND_W = 4;

  // 128-bit key/state; byte k lives at [127-8k -: 8], word j at [127-32j -: 32].
  typedef logic [127:0]       aesBlock_t;
  typedef logic [ROUND_W-1:0] round_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } expState_t;

  // Round constants in application order; the schedule regenerates them with xtime.
  localparam logic [7:0] RCON [AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of a block, column-major: byte k feeds matrix cell (k%4, k/4).
  function automatic logic [7:0] keyByte(input aesBlock_t blk, input int unsigned k);
    return blk[127-8*k -: 8];
  endfunction

  // Word j of a block (bytes 4j..4j+3).
  function automatic logic [31:0] keyWord(input aesBlock_t blk, input int unsigned j);
    return blk[127-32*j -: 32];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Purpose: AES forward S-box, one byte in, one byte out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Row r of the table holds S(16r)..S(16r+15), entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Top bit of entry i is 2047-8i, which is exactly {~i, 3'b111}.
  assign o_byte = SBOX_TABLE[{~i_byte, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_expand_iter.sv
// Purpose: iterative AES-128 key schedule, one round key per accepted beat.
// Latency: round 0 valid the cycle after start; then one key per handshake.
// Backpressure: i_ready low holds key/round/valid stable; outputs never depend on i_ready.
module aes_key_expand_iter
  import aes_pkg::*;
#(
  parameter int        NR      = AES_NR,
  parameter aesBlock_t RST_KEY = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [127:0] i_key,
  output logic         o_busy,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_roundKey,
  output logic [3:0]   o_round,
  output logic         o_last,
  output logic         o_done
);

  localparam round_t LAST_ROUND = round_t'(NR);

  expState_t   state, nextState;
  aesBlock_t   keyReg, nextKey;
  round_t      roundReg;
  logic [7:0]  rconReg;
  logic        doneReg;
  logic        startAccept, handshake, advance, finish;
  logic [31:0] w0, w1, w2, w3, rotWord, subWord, tWord, n0, n1, n2, n3;

  assign startAccept = (state == IDLE) && i_start;
  assign handshake   = (state == EMIT) && i_ready;
  assign advance     = handshake && (roundReg != LAST_ROUND);
  assign finish      = handshake && (roundReg == LAST_ROUND);

  // Next round key, purely combinational from the registered key.
  assign w0      = keyWord(keyReg, 0);
  assign w1      = keyWord(keyReg, 1);
  assign w2      = keyWord(keyReg, 2);
  assign w3      = keyWord(keyReg, 3);
  assign rotWord = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : gSbox
    aes_sbox uSbox (
      .i_byte(rotWord[8*g +: 8]),
      .o_byte(subWord[8*g +: 8])
    );
  end

  assign tWord   = subWord ^ {rconReg, 24'h0};
  assign n0      = w0 ^ tWord;
  assign n1      = n0 ^ w1;
  assign n2      = n1 ^ w2;
  assign n3      = n2 ^ w3;
  assign nextKey = {n0, n1, n2, n3};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next state: start leaves IDLE; the handshake on the last key returns to it.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (i_start) nextState = EMIT;
      EMIT:    if (finish)  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only, so stalls cannot glitch them.
  always_comb begin
    o_valid = (state == EMIT);
    o_busy  = (state == EMIT);
    o_last  = (state == EMIT) && (roundReg == LAST_ROUND);
  end

  // Key, round index and rcon: load on start, step on each non-final handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      keyReg   <= RST_KEY;
      roundReg <= '0;
      rconReg  <= RCON[0];
    end else if (startAccept) begin
      keyReg   <= i_key;
      roundReg <= '0;
      rconReg  <= RCON[0];
    end else if (advance) begin
      keyReg   <= nextKey;
      roundReg <= roundReg + round_t'(1);
      rconReg  <= xtime(rconReg);
    end
  end

  // Completion pulse, one cycle after the final key is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) doneReg <= 1'b0;
    else          doneReg <= finish;
  end

  assign o_roundKey = keyReg;
  assign o_round    = roundReg;
  assign o_done     = doneReg;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
module tb_aes_key_expand_iter;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [127:0] i_key;
  logic         o_busy;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_roundKey;
  logic [3:0]   o_round;
  logic         o_last;
  logic         o_done;

  int checks   = 0;
  int failures = 0;

  logic [127:0] fipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] zeroR1  = 128'h62636363626363636263636362636363;
  logic [127:0] zeroR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic [127:0] fipsKeys [11];

  aes_key_expand_iter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_key(i_key),
    .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready),
    .o_roundKey(o_roundKey), .o_round(o_round), .o_last(o_last), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Pulse start for one cycle; returns at the negedge where round 0 should be visible.
  task automatic startExp(input logic [127:0] k);
    @(negedge i_clk);
    i_start = 1'b1;
    i_key   = k;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_start = 1'b0; i_ready = 1'b0; i_key = '0;
    #12;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_roundKey !== 128'h0) begin failures++; $display("FAIL reset_key got=%h exp=0", o_roundKey); end
    checks++; if (o_round !== 4'd0) begin failures++; $display("FAIL reset_round got=%0d exp=0", o_round); end
    checks++; if ({o_last, o_done} !== 2'b00) begin failures++; $display("FAIL reset_last_done got=%b exp=00", {o_last, o_done}); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", o_valid); end
  endtask

  task automatic test_fips_stream;
    i_ready = 1'b1;
    startExp(fipsKey);
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) @(negedge i_clk);
      checks++; if (o_valid !== 1'b1 || o_busy !== 1'b1) begin failures++; $display("FAIL fips_valid r=%0d got v=%b b=%b exp 1", r, o_valid, o_busy); end
      checks++; if (o_roundKey !== fipsKeys[r]) begin failures++; $display("FAIL fips_key r=%0d got=%h exp=%h", r, o_roundKey, fipsKeys[r]); end
      checks++; if (o_round !== 4'(r)) begin failures++; $display("FAIL fips_round got=%0d exp=%0d", o_round, r); end
      checks++; if (o_last !== (r == 10)) begin failures++; $display("FAIL fips_last r=%0d got=%b", r, o_last); end
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL fips_early_done r=%0d got=%b exp=0", r, o_done); end
    end
    @(negedge i_clk);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL fips_done got=%b exp=1", o_done); end
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL fips_idle got v=%b b=%b exp 0", o_valid, o_busy); end
    checks++; if (o_roundKey !== fipsKeys[10] || o_round !== 4'd10) begin failures++; $display("FAIL fips_hold got=%h/%0d exp=%h/10", o_roundKey, o_round, fipsKeys[10]); end
    @(negedge i_clk);
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL fips_done_pulse got=%b exp=0", o_done); end
  endtask

  task automatic test_zero_key;
    i_ready = 1'b1;
    startExp(128'h0);
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) @(negedge i_clk);
      checks++; if (o_round !== 4'(r)) begin failures++; $display("FAIL zero_round got=%0d exp=%0d", o_round, r); end
      if (r == 0) begin
        checks++; if (o_roundKey !== 128'h0) begin failures++; $display("FAIL zero_r0 got=%h exp=0", o_roundKey); end
      end
      if (r == 1) begin
        checks++; if (o_roundKey !== zeroR1) begin failures++; $display("FAIL zero_r1 got=%h exp=%h", o_roundKey, zeroR1); end
      end
      if (r == 10) begin
        checks++; if (o_roundKey !== zeroR10) begin failures++; $display("FAIL zero_r10 got=%h exp=%h", o_roundKey, zeroR10); end
      end
    end
    @(negedge i_clk);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", o_done); end
  endtask

  task automatic test_stall;
    logic [15:0] pat = 16'b0110_1001_0011_1001;
    int idx = 0;
    int cyc = 0;
    startExp(fipsKey);
    while (cyc < 200 && idx <= 10) begin
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", cyc, o_valid); end
      checks++; if (o_roundKey !== fipsKeys[idx]) begin failures++; $display("FAIL stall_key cyc=%0d got=%h exp=%h", cyc, o_roundKey, fipsKeys[idx]); end
      checks++; if (o_round !== 4'(idx)) begin failures++; $display("FAIL stall_round cyc=%0d got=%0d exp=%0d", cyc, o_round, idx); end
      i_ready = pat[cyc % 16];
      if (i_ready) idx++;
      cyc++;
      @(negedge i_clk);
    end
    checks++; if (idx != 11) begin failures++; $display("FAIL stall_timeout accepted=%0d exp=11", idx); end
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", o_done); end
    i_ready = 1'b1;
  endtask

  task automatic test_start_ignored;
    i_ready = 1'b1;
    startExp(fipsKey);
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) @(negedge i_clk);
      if (r == 5) i_start = 1'b0;
      checks++; if (o_roundKey !== fipsKeys[r] || o_round !== 4'(r)) begin failures++; $display("FAIL ign_key r=%0d got=%h/%0d exp=%h", r, o_roundKey, o_round, fipsKeys[r]); end
      if (r == 4) begin
        i_start = 1'b1;
        i_key   = 128'hffeeddccbbaa99887766554433221100;
      end
    end
    @(negedge i_clk);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", o_done); end
  endtask

  task automatic test_reset_mid;
    i_ready = 1'b1;
    startExp(fipsKey);
    repeat (6) @(negedge i_clk);
    checks++; if (o_round !== 4'd6) begin failures++; $display("FAIL rst_pre_round got=%0d exp=6", o_round); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL rst_async_vb got v=%b b=%b exp 0", o_valid, o_busy); end
    checks++; if (o_roundKey !== 128'h0 || o_round !== 4'd0) begin failures++; $display("FAIL rst_async_key got=%h/%0d exp=0/0", o_roundKey, o_round); end
    checks++; if ({o_last, o_done} !== 2'b00) begin failures++; $display("FAIL rst_async_ld got=%b exp=00", {o_last, o_done}); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checks++; if (o_done !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL rst_no_done c=%0d got d=%b v=%b exp 0", c, o_done, o_valid); end
    end
    startExp(fipsKey);
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) @(negedge i_clk);
      checks++; if (o_roundKey !== fipsKeys[r]) begin failures++; $display("FAIL rst_restart_key r=%0d got=%h exp=%h", r, o_roundKey, fipsKeys[r]); end
    end
    @(negedge i_clk);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL rst_restart_done got=%b exp=1", o_done); end
  endtask

  task automatic test_back_to_back;
    bit sawDone = 1'b0;
    i_ready = 1'b1;
    startExp(fipsKey);
    repeat (10) @(negedge i_clk);
    checks++; if (o_last !== 1'b1) begin failures++; $display("FAIL b2b_last got=%b exp=1", o_last); end
    @(negedge i_clk);
    checks++; if (o_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", o_done); end
    i_start = 1'b1;
    i_key   = 128'h0;
    @(negedge i_clk);
    i_start = 1'b0;
    checks++; if (o_valid !== 1'b1 || o_roundKey !== 128'h0 || o_round !== 4'd0) begin failures++; $display("FAIL b2b_r0 got v=%b %h/%0d exp 1 0/0", o_valid, o_roundKey, o_round); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL b2b_done_clear got=%b exp=0", o_done); end
    @(negedge i_clk);
    checks++; if (o_roundKey !== zeroR1 || o_round !== 4'd1) begin failures++; $display("FAIL b2b_r1 got=%h/%0d exp=%h/1", o_roundKey, o_round, zeroR1); end
    for (int c = 0; c < 20 && !sawDone; c++) begin
      @(negedge i_clk);
      sawDone = o_done;
    end
    checks++; if (!sawDone) begin failures++; $display("FAIL b2b_drain_timeout done=%b exp=1", sawDone); end
  endtask

  initial begin
    fipsKeys = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    test_reset();
    test_fips_stream();
    test_zero_key();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
